i2c_bus_arbiter: RTL

//  Shares one I2C_Controller (24-bit {slave,sub,data} write engine) between NREQ requesters,
//  e.g. HDMI config sequencer, runtime AR/audio-rate updater, scaler/audio codec config.

---
 rtl/i2c_bus_arbiter_pkg.sv | 28 ++
 rtl/i2c_bus_arbiter_rr_pick.sv | 41 ++++
 rtl/i2c_bus_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/i2c_bus_arbiter_pkg.sv
// i2c_arb_pkg: shared types for the I2C bus arbiter.
//   state_e     arbiter FSM states
//   I2C_WORD_W  width of one controller word {slave,sub,data}
//   req_word_t  field view of that word
//   ptr_w()     width of a requester index for a given requester count
package i2c_arb_pkg;

  localparam int I2C_WORD_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    XFER,
    RESP
  } state_e;

  typedef struct packed {
    logic [7:0] slave;
    logic [7:0] sub;
    logic [7:0] data;
  } req_word_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin finder.
//   valid [N-1:0]  pending requests
//   ptr   [PW-1:0] highest-priority index this round (< N)
//   idx   [PW-1:0] first valid index at or after ptr, wrapping at N
//   hit            some request is valid
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          hit
);

  // Rotate so bit 0 of rot is the request at ptr; the lowest set bit of rot wins.
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rot;

  assign dbl     = {valid, valid};
  assign shifted = dbl >> ptr;
  assign rot     = shifted[N-1:0];

  always_comb begin
    int s;
    idx = '0;
    hit = 1'b0;
    s   = 0;
    // Walk downward so the smallest offset is the last (winning) assignment.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        s = int'(ptr) + k;
        if (s >= N) s = s - N;
        idx = PW'(s);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one I2C_Controller write engine between NREQ requesters.
// Round-robin grant, one transfer at a time, automatic retry on NACK.
//   iCLK, iRST_N         clock, asynchronous active-low reset
//   req_valid/req_data   per-requester request and 24-bit {slave,sub,data} word
//   req_ready            one-cycle accept pulse to the granted requester
//   done/err             one-cycle completion pulse, err set on final NACK or timeout
//   busy                 grant through done pulse
//   ctl_data/ctl_start   to the controller; ctl_end/ctl_ack from it (ack=1 is NACK)
// Optional macro I2C_ARB_TIMEOUT_EN: per-attempt cycle limit TIMEOUT_CYC, abort with err.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                       iCLK,
  input  logic                       iRST_N,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*I2C_WORD_W-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            done,
  output logic [NREQ-1:0]            err,
  output logic                       busy,
  output logic [I2C_WORD_W-1:0]      ctl_data,
  output logic                       ctl_start,
  input  logic                       ctl_end,
  input  logic                       ctl_ack
);

  localparam int PW = ptr_w(NREQ);

  if (NREQ < 2 || NREQ > 8 || MAX_RETRY < 0 || MAX_RETRY > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("i2c_bus_arbiter: parameter out of range");
  end

  state_e        state, nxt;
  logic [PW-1:0] rr_ptr, gnt, pick_idx;
  logic          pick_hit;
  req_word_t     word_q;
  logic [3:0]    retry_cnt;
  logic          err_q;
  logic          tmo_hit;
  logic          retry_ok;

  logic [NREQ-1:0][I2C_WORD_W-1:0] req_words;
  assign req_words = req_data;
  assign retry_ok  = retry_cnt < 4'(MAX_RETRY);

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .hit   (pick_hit)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  // Cleared on every entry to START so each retry gets a full budget.
  logic [31:0] tmo_cnt;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                           tmo_cnt <= '0;
    else if (nxt == START && state != START) tmo_cnt <= '0;
    else if (state == START || state == XFER) tmo_cnt <= tmo_cnt + 32'd1;
  end
  assign tmo_hit = (state == START || state == XFER) && (tmo_cnt >= 32'(TIMEOUT_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nxt;
  end

  // Next state
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (|req_valid) nxt = GRANT;
      // A request withdrawn before the grant cycle is simply dropped.
      GRANT: nxt = pick_hit ? START : IDLE;
      START: begin
        if (tmo_hit)       nxt = RESP;
        else if (!ctl_end) nxt = XFER;
      end
      XFER: begin
        if (tmo_hit) nxt = RESP;
        else if (ctl_end) begin
          if (ctl_ack && retry_ok) nxt = START;
          else                     nxt = RESP;
        end
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Grant latch, retry counter, error flag
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      word_q    <= '0;
      retry_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        GRANT: if (pick_hit) begin
          gnt       <= pick_idx;
          word_q    <= req_word_t'(req_words[pick_idx]);
          retry_cnt <= '0;
          err_q     <= 1'b0;
          rr_ptr    <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
        end
        START: if (tmo_hit) err_q <= 1'b1;
        XFER: begin
          if (tmo_hit) err_q <= 1'b1;
          else if (ctl_end && ctl_ack) begin
            if (retry_ok) retry_cnt <= retry_cnt + 4'd1;
            else          err_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from state so reset clears them immediately.
  always_comb begin
    req_ready = '0;
    done      = '0;
    err       = '0;
    busy      = 1'b0;
    ctl_start = 1'b0;
    case (state)
      GRANT: begin
        busy      = pick_hit;
        req_ready = pick_hit ? (NREQ'(1) << pick_idx) : '0;
      end
      START: begin
        busy      = 1'b1;
        ctl_start = !tmo_hit;
      end
      XFER: busy = 1'b1;
      RESP: begin
        busy = 1'b1;
        done = NREQ'(1) << gnt;
        err  = err_q ? (NREQ'(1) << gnt) : '0;
      end
      default: ;
    endcase
  end

  assign ctl_data = word_q;

endmodule
